// File: rtl/register_file_pkg.sv
// Shared types and sizes for the architectural register file and its read ports.
// ROB_SIZE_BIT comes from the shared config; a local default keeps standalone builds complete.
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif

package register_file_pkg;
    localparam int ROB_SIZE_BIT = `ROB_SIZE_BIT;
    localparam int REG_IDX_W    = 5;
    localparam int REG_NUM      = 32;
    localparam int TAG_W        = ROB_SIZE_BIT;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [31:0]          word_t;

    typedef struct packed {
        word_t val;
        logic  busy;
        tag_t  dep;
    } rf_query_t;
endpackage

// File: rtl/rf_read_port.sv
// One operand query port: forces x0 to zero/idle and selects a commit-bypass value when the
// parent flags a hit (the hit is only ever raised when RF_COMMIT_BYPASS_EN is defined).
module rf_read_port
    import register_file_pkg::*;
(
    input  reg_idx_t  idx,
    input  word_t     stored_val,
    input  logic      stored_busy,
    input  tag_t      stored_dep,
    input  logic      bypass_hit,
    input  word_t     bypass_val,
    output rf_query_t q
);
    always_comb begin
        q = '0;
        if (idx != '0) begin
            if (bypass_hit) begin
                q.val = bypass_val;
            end else begin
                q.val  = stored_val;
                q.busy = stored_busy;
                q.dep  = stored_busy ? stored_dep : '0;
            end
        end
    end
endmodule

// File: rtl/register_file.sv
// Architectural register file x0..x31 with per-register rename tag (busy + youngest ROB writer).
// Optional macro RF_COMMIT_BYPASS_EN forwards a same-cycle committing value to the query ports.
module register_file
    import register_file_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear,
    input  logic [4:0]       rob_set_idx,
    input  logic [31:0]      rob_set_reg_val,
    input  logic [TAG_W-1:0] rob_set_recorder,
    input  logic [4:0]       rf_set_idx,
    input  logic [TAG_W-1:0] rf_set_dep,
    input  logic [4:0]       rs1_idx,
    input  logic [4:0]       rs2_idx,
    output logic [31:0]      rs1_val,
    output logic [31:0]      rs2_val,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic [TAG_W-1:0] rs1_dep,
    output logic [TAG_W-1:0] rs2_dep
);
    word_t val  [REG_NUM];
    logic  busy [REG_NUM];
    tag_t  dep  [REG_NUM];

    logic commit, rename, commit_frees;
    assign commit = rob_set_idx != '0;
    assign rename = rf_set_idx != '0;
    // A same-cycle rename of the committing register makes the rename the youngest writer.
    assign commit_frees = commit && (dep[rob_set_idx] == rob_set_recorder)
                          && !(rename && rf_set_idx == rob_set_idx);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val[i]  <= '0;
                busy[i] <= 1'b0;
                dep[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (clear) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    busy[i] <= 1'b0;
                    dep[i]  <= '0;
                end
            end else begin
                if (commit) begin
                    val[rob_set_idx] <= rob_set_reg_val;
                    if (commit_frees) begin
                        busy[rob_set_idx] <= 1'b0;
                        dep[rob_set_idx]  <= '0;
                    end
                end
                if (rename) begin
                    busy[rf_set_idx] <= 1'b1;
                    dep[rf_set_idx]  <= rf_set_dep;
                end
            end
        end
    end

    reg_idx_t  rs_idx [2];
    logic      hit    [2];
    rf_query_t q      [2];

    assign rs_idx[0] = rs1_idx;
    assign rs_idx[1] = rs2_idx;

    for (genvar p = 0; p < 2; p++) begin : g_port
`ifdef RF_COMMIT_BYPASS_EN
        assign hit[p] = rdy_in && !clear && commit && (rs_idx[p] == rob_set_idx)
                        && (dep[rob_set_idx] == rob_set_recorder);
`else
        assign hit[p] = 1'b0;
`endif
        rf_read_port u_port (
            .idx         (rs_idx[p]),
            .stored_val  (val[rs_idx[p]]),
            .stored_busy (busy[rs_idx[p]]),
            .stored_dep  (dep[rs_idx[p]]),
            .bypass_hit  (hit[p]),
            .bypass_val  (rob_set_reg_val),
            .q           (q[p])
        );
    end

    assign rs1_val  = q[0].val;
    assign rs1_busy = q[0].busy;
    assign rs1_dep  = q[0].dep;
    assign rs2_val  = q[1].val;
    assign rs2_busy = q[1].busy;
    assign rs2_dep  = q[1].dep;
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: rename/commit/clear/freeze/x0 cases with hand-derived values.
module tb_register_file;
    import register_file_pkg::*;

    logic             clk_in = 1'b0;
    logic             rst_in, rdy_in, clear;
    logic [4:0]       rob_set_idx, rf_set_idx, rs1_idx, rs2_idx;
    logic [31:0]      rob_set_reg_val;
    logic [TAG_W-1:0] rob_set_recorder, rf_set_dep;
    logic [31:0]      rs1_val, rs2_val;
    logic             rs1_busy, rs2_busy;
    logic [TAG_W-1:0] rs1_dep, rs2_dep;

    int vectors = 0;
    int errors  = 0;

    register_file dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .rob_set_idx(rob_set_idx), .rob_set_reg_val(rob_set_reg_val),
        .rob_set_recorder(rob_set_recorder), .rf_set_idx(rf_set_idx), .rf_set_dep(rf_set_dep),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_dep(rs1_dep), .rs2_dep(rs2_dep)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        clear = 0; rob_set_idx = 0; rob_set_reg_val = 0; rob_set_recorder = 0;
        rf_set_idx = 0; rf_set_dep = 0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        idle();
        #1;
    endtask

    task automatic rename(input logic [4:0] r, input logic [TAG_W-1:0] t);
        rf_set_idx = r; rf_set_dep = t;
        tick();
    endtask

    initial begin
        rst_in = 1; rdy_in = 1; rs1_idx = 0; rs2_idx = 0;
        idle();
        tick(); tick();
        rst_in = 0;

        // 1: reset state
        rs1_idx = 5; rs2_idx = 0; #1;
        chk("rst_rs1_val", rs1_val, 0);
        chk("rst_rs1_busy", 32'(rs1_busy), 0);
        chk("rst_rs1_dep", 32'(rs1_dep), 0);
        chk("rst_rs2_val", rs2_val, 0);
        chk("rst_rs2_busy", 32'(rs2_busy), 0);

        // 2: rename then matching commit
        rename(5, 3);
        chk("ren_x5_busy", 32'(rs1_busy), 1);
        chk("ren_x5_dep", 32'(rs1_dep), 3);
        chk("ren_x5_val", rs1_val, 0);
        rob_set_idx = 5; rob_set_reg_val = 32'hDEADBEEF; rob_set_recorder = 3;
        tick();
        chk("cmt_x5_val", rs1_val, 32'hDEADBEEF);
        chk("cmt_x5_busy", 32'(rs1_busy), 0);
        chk("cmt_x5_dep", 32'(rs1_dep), 0);

        // 3: older writer commits, younger rename kept
        rename(7, 2);
        rename(7, 6);
        rob_set_idx = 7; rob_set_reg_val = 32'h11; rob_set_recorder = 2;
        tick();
        rs1_idx = 7; #1;
        chk("old_x7_val", rs1_val, 32'h11);
        chk("old_x7_busy", 32'(rs1_busy), 1);
        chk("old_x7_dep", 32'(rs1_dep), 6);

        // 4: same-cycle commit and rename of x9
        rename(9, 4);
        rob_set_idx = 9; rob_set_reg_val = 32'h99; rob_set_recorder = 4;
        rf_set_idx = 9; rf_set_dep = 5;
        tick();
        rs2_idx = 9; #1;
        chk("same_x9_val", rs2_val, 32'h99);
        chk("same_x9_busy", 32'(rs2_busy), 1);
        chk("same_x9_dep", 32'(rs2_dep), 5);

        // commit and rename to different regs both land
        rob_set_idx = 7; rob_set_reg_val = 32'h77; rob_set_recorder = 6;
        rf_set_idx = 8; rf_set_dep = 1;
        tick();
        rs1_idx = 7; rs2_idx = 8; #1;
        chk("diff_x7_val", rs1_val, 32'h77);
        chk("diff_x7_busy", 32'(rs1_busy), 0);
        chk("diff_x8_busy", 32'(rs2_busy), 1);
        chk("diff_x8_dep", 32'(rs2_dep), 1);

        // 5: clear drops tags, ignores same-cycle commit
        rename(1, 1);
        rename(2, 2);
        clear = 1; rob_set_idx = 1; rob_set_reg_val = 32'h55; rob_set_recorder = 1;
        tick();
        rs1_idx = 1; rs2_idx = 2; #1;
        chk("clr_x1_busy", 32'(rs1_busy), 0);
        chk("clr_x1_val", rs1_val, 0);
        chk("clr_x2_busy", 32'(rs2_busy), 0);
        chk("clr_x2_dep", 32'(rs2_dep), 0);
        rs1_idx = 9; rs2_idx = 5; #1;
        chk("clr_x9_busy", 32'(rs1_busy), 0);
        chk("clr_x9_val", rs1_val, 32'h99);
        chk("clr_x5_val", rs2_val, 32'hDEADBEEF);

        // 6: freeze and x0
        rdy_in = 0;
        rename(3, 7);
        rdy_in = 1;
        rs1_idx = 3; #1;
        chk("frz_x3_busy", 32'(rs1_busy), 0);
        chk("frz_x3_dep", 32'(rs1_dep), 0);
        rdy_in = 0; rob_set_idx = 5; rob_set_reg_val = 32'hBAD; rob_set_recorder = 0;
        tick();
        rdy_in = 1;
        rs1_idx = 5; #1;
        chk("frz_x5_val", rs1_val, 32'hDEADBEEF);
        rf_set_idx = 0; rf_set_dep = 4;
        rename(0, 4);
        rob_set_idx = 0; rob_set_reg_val = 32'h1234; rob_set_recorder = 4;
        tick();
        rs1_idx = 0; #1;
        chk("x0_val", rs1_val, 0);
        chk("x0_busy", 32'(rs1_busy), 0);
        chk("x0_dep", 32'(rs1_dep), 0);

        // 7: commit visible in the query path the same cycle only with bypass
        rename(5, 3);
        rs1_idx = 5;
        rob_set_idx = 5; rob_set_reg_val = 32'h42; rob_set_recorder = 3;
        #1;
`ifdef RF_COMMIT_BYPASS_EN
        chk("byp_val", rs1_val, 32'h42);
        chk("byp_busy", 32'(rs1_busy), 0);
        chk("byp_dep", 32'(rs1_dep), 0);
`else
        chk("nobyp_val", rs1_val, 32'hDEADBEEF);
        chk("nobyp_busy", 32'(rs1_busy), 1);
        chk("nobyp_dep", 32'(rs1_dep), 3);
`endif
        tick();
        chk("post_x5_val", rs1_val, 32'h42);
        chk("post_x5_busy", 32'(rs1_busy), 0);

        // reset clears stored values too
        rst_in = 1;
        tick();
        rst_in = 0; #1;
        chk("rst2_x5_val", rs1_val, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
